ram_burst_master: RTL

//  Initiator side of the single-port RAM interface (cs/rd/wr/addr/din/dout, 1-cycle read latency).

---
 rtl/ram_burst_master.sv | 115 +++++++++++
 1 files changed

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM with 1-cycle read latency.
// Takes valid/ready burst commands and sequences RAM strobes beat by beat.
module ram_burst_master #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              ram_cs,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              rvalid_q;

    // Next-state, counter updates and all RAM/handshake outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        ram_cs      = 1'b0;
        ram_rd      = 1'b0;
        ram_wr      = 1'b0;
        ram_addr    = addr_q;
        ram_din     = wdata;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                wdata_ready = 1'b1;
                ram_cs      = wdata_valid;
                ram_wr      = wdata_valid;
                if (wdata_valid) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_READ: begin
                ram_cs = 1'b1;
                ram_rd = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - LEN_W'(1);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, address/beat counters and read-valid pipeline register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= ram_rd;
        end
    end

    assign rdata_valid = rvalid_q;
    assign rdata       = ram_dout;

endmodule
